// File: rtl/fmap_pkg.sv
// Shared types and sizing helpers for the feature-map replay FIFO.
package fmap_pkg;

  localparam int DATA_W_DEF = 32;

  typedef logic signed [DATA_W_DEF-1:0] fmap_word_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width able to address 0..depth-1 (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fmap_mod_ptr.sv
// Modulo-DEPTH pointer: increments with wrap from DEPTH-1 to 0; load has priority.
module fmap_mod_ptr
  import fmap_pkg::*;
#(
  parameter int DEPTH = 150,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fmap_replay_fifo.sv
// Feature-map FIFO with tile replay: reads are held until committed and may be rewound.
module fmap_replay_fifo
  import fmap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 150,
  parameter int WR_LAT = 1,
  parameter int AF_LVL = DEPTH - 4,
  localparam int CW = cnt_w(DEPTH),
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     rd_rewind,
  input  logic                     rd_commit,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_vld,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [CW-1:0]            used_cnt,
  output logic [CW-1:0]            avail_cnt,
  output logic                     ovf,
  udf
);

  logic                     wq;
  logic signed [DATA_W-1:0] wq_din;
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     rewind_eff;
  logic [CW-1:0]            rel;
  logic [CW-1:0]            used_nxt;
  logic [CW-1:0]            avail_nxt;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            base_ptr;
  logic signed [DATA_W-1:0] mem [DEPTH];

  // p0 -> p1: optional input stage; enable and data travel together
  if (WR_LAT != 0) begin : g_wr_pipe
    logic                     wr_en_p1;
    logic signed [DATA_W-1:0] din_p1;

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_en_p1 <= 1'b0;
        din_p1   <= '0;
      end else begin
        wr_en_p1 <= wr_en;
        din_p1   <= din;
      end
    end

    assign wq     = wr_en_p1;
    assign wq_din = din_p1;
  end else begin : g_wr_direct
    assign wq     = wr_en;
    assign wq_din = din;
  end

  assign full        = (used_cnt == CW'(DEPTH));
  assign empty       = (avail_cnt == '0);
  assign almost_full = (used_cnt >= CW'(AF_LVL));

  assign wr_acc     = wq && !full;
  assign rd_acc     = rd_en && !empty && !rd_rewind;
  assign rewind_eff = rd_rewind && !rd_commit;

  always_comb begin
    rel       = rd_commit ? (used_cnt - avail_cnt) : '0;
    used_nxt  = used_cnt + CW'(wr_acc) - rel;
    avail_nxt = rewind_eff ? (used_cnt + CW'(wr_acc))
                           : (avail_cnt + CW'(wr_acc) - CW'(rd_acc));
  end

  fmap_mod_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (wr_acc),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wr_ptr)
  );

  // A rewind returns the read pointer to the oldest uncommitted entry.
  fmap_mod_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (rd_acc),
    .load     (rewind_eff),
    .load_val (base_ptr),
    .ptr      (rd_ptr)
  );

  fmap_mod_ptr #(.DEPTH(DEPTH)) u_base_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (1'b0),
    .load     (rd_commit),
    .load_val (rd_ptr),
    .ptr      (base_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wq_din;
    end
  end

  // p1 -> p2: registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (rd_acc) begin
      dout <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used_cnt  <= '0;
      avail_cnt <= '0;
      dout_vld  <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      used_cnt  <= used_nxt;
      avail_cnt <= avail_nxt;
      dout_vld  <= rd_acc;
      if (wq && full) begin
        ovf <= 1'b1;
      end
      if (rd_en && empty && !rd_rewind) begin
        udf <= 1'b1;
      end
    end
  end

endmodule
